image_loader: RTL and testbench

IMAGE_LOADER -- requirements
Module: image_loader

---
 rtl/cnn_pkg.sv | 15 +
 rtl/sat_counter.sv | 23 ++
 rtl/image_loader.sv | 155 +++++++++++++++
 tb/tb_image_loader.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared types and constants for the CNN front end: frame geometry, class count and loader states.
package cnn_pkg;

  localparam int IMAGE_PIXELS = 784;
  localparam int NUM_CLASSES  = 10;
  localparam int PIX_W        = 8;

  typedef enum logic [1:0] {
    RECV_LABEL,
    RECV_PIX,
    LAUNCH,
    WAIT_DONE
  } loader_state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_count = r_cnt;

endmodule

// File: rtl/image_loader.sv
// Loads a label byte plus IMAGE_PIXELS pixel bytes, pulses start, then waits for the CNN's done.
// Statistics counters (frame_count/correct_count) exist only when LOADER_STATS_EN is defined.
module image_loader #(
  parameter int IMAGE_PIXELS = cnn_pkg::IMAGE_PIXELS,
  parameter int CNT_W        = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [7:0]                             in_data,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  output logic [cnn_pkg::PIX_W*IMAGE_PIXELS-1:0] image_data,
  output logic [3:0]                             label,
  output logic                                   start,
  input  logic                                   done,
  input  logic [3:0]                             classification,
  output logic                                   busy,
  output logic                                   label_err,
  output logic [CNT_W-1:0]                       frame_count,
  output logic [CNT_W-1:0]                       correct_count
);
  import cnn_pkg::*;

  localparam int               IDX_W    = (IMAGE_PIXELS > 1) ? $clog2(IMAGE_PIXELS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IMAGE_PIXELS - 1);

  loader_state_t                 r_state;
  loader_state_t                 w_next;
  logic [IDX_W-1:0]              r_idx;
  logic [PIX_W*IMAGE_PIXELS-1:0] r_image;
  logic [3:0]                    r_label;
  logic                          r_label_err;

  logic w_label_ok;
  logic w_label_take;
  logic w_label_drop;
  logic w_pix_take;
  logic w_done_ok;
  logic w_in_ready;
  logic w_start;
  logic w_busy;

  assign w_label_ok = (in_data < 8'(NUM_CLASSES));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RECV_LABEL;
    end else begin
      r_state <= w_next;
    end
  end

  // done is only looked at once we are already sitting in WAIT_DONE, so a
  // pulse coinciding with the LAUNCH cycle is never honoured.
  always_comb begin
    w_next       = r_state;
    w_in_ready   = 1'b0;
    w_start      = 1'b0;
    w_busy       = 1'b1;
    w_label_take = 1'b0;
    w_label_drop = 1'b0;
    w_pix_take   = 1'b0;
    w_done_ok    = 1'b0;
    case (r_state)
      RECV_LABEL: begin
        w_in_ready = 1'b1;
        w_busy     = 1'b0;
        if (in_valid) begin
          if (w_label_ok) begin
            w_label_take = 1'b1;
            w_next       = RECV_PIX;
          end else begin
            w_label_drop = 1'b1;
          end
        end
      end
      RECV_PIX: begin
        w_in_ready = 1'b1;
        if (in_valid) begin
          w_pix_take = 1'b1;
          if (r_idx == LAST_IDX) begin
            w_next = LAUNCH;
          end
        end
      end
      LAUNCH: begin
        w_start = 1'b1;
        w_next  = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (done) begin
          w_done_ok = 1'b1;
          w_next    = RECV_LABEL;
        end
      end
      default: begin
        w_next = RECV_LABEL;
      end
    endcase
  end

  // Image and label only change while receiving, which keeps them stable for the CNN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx       <= '0;
      r_label     <= '0;
      r_image     <= '0;
      r_label_err <= 1'b0;
    end else begin
      r_label_err <= w_label_drop;
      if (w_label_take) begin
        r_label <= in_data[3:0];
        r_idx   <= '0;
      end
      if (w_pix_take) begin
        r_image[{r_idx, 3'b000} +: PIX_W] <= in_data;
        if (r_idx != LAST_IDX) begin
          r_idx <= r_idx + 1'b1;
        end
      end
    end
  end

  assign in_ready   = w_in_ready;
  assign start      = w_start;
  assign busy       = w_busy;
  assign label      = r_label;
  assign label_err  = r_label_err;
  assign image_data = r_image;

`ifdef LOADER_STATS_EN
  logic w_correct;
  assign w_correct = w_done_ok && (classification == r_label);

  sat_counter #(.W(CNT_W)) u_frame_cnt (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_inc   (w_done_ok),
    .o_count (frame_count)
  );

  sat_counter #(.W(CNT_W)) u_correct_cnt (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_inc   (w_correct),
    .o_count (correct_count)
  );
`else
  logic w_unused_stats;
  assign w_unused_stats = ^{classification, w_done_ok};
  assign frame_count    = '0;
  assign correct_count  = '0;
`endif

endmodule

// File: tb/tb_image_loader.sv
// Table-driven bench for image_loader with a start-triggered image/label scoreboard.
module tb_image_loader;
  import cnn_pkg::*;

  localparam int NP = 784;
  localparam int CW = 16;
`ifdef LOADER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [7:0]      in_data;
  logic            in_valid;
  logic            in_ready;
  logic [8*NP-1:0] image_data;
  logic [3:0]      label;
  logic            start;
  logic            done;
  logic [3:0]      classification;
  logic            busy;
  logic            label_err;
  logic [CW-1:0]   frame_count;
  logic [CW-1:0]   correct_count;

  image_loader #(.IMAGE_PIXELS(NP), .CNT_W(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .image_data     (image_data),
    .label          (label),
    .start          (start),
    .done           (done),
    .classification (classification),
    .busy           (busy),
    .label_err      (label_err),
    .frame_count    (frame_count),
    .correct_count  (correct_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]      lbl;
    logic [8*NP-1:0] img;
  } exp_t;

  typedef struct {
    bit         bad_en;
    logic [7:0] bad_byte;
    logic [7:0] lbl_byte;
    int         mul;
    int         add;
    bit         gappy;
    bit         early_done;
    logic [3:0] cls;
    logic [3:0] exp_label;
    bit         exp_correct;
  } vec_t;

  exp_t       sb[$];
  exp_t       mon_e;
  vec_t       vecs[5];
  int         tests = 0;
  int         fails = 0;
  int         starts = 0;
  int         fc_m = 0;
  int         cc_m = 0;
  logic [3:0] label_m = 4'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_img(input string name, input logic [8*NP-1:0] exp);
    int bad = 0;
    for (int k = 0; k < NP; k++) begin
      if (image_data[8*k +: 8] !== exp[8*k +: 8]) bad++;
    end
    check(name, bad, 0);
  endtask

  function automatic int sat_inc(input int v);
    return (v < 65535) ? v + 1 : v;
  endfunction

  function automatic int exp_cnt(input int v);
    return STATS ? v : 0;
  endfunction

  // Scoreboard consumer: each start must match the oldest pending frame.
  always @(negedge clk) begin
    if (rst === 1'b0 && start === 1'b1) begin
      starts++;
      if (sb.size() == 0) begin
        check("start_unexpected", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("sb_label", label, mon_e.lbl);
        check_img("sb_image", mon_e.img);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bit ok = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      ok       = in_ready;
      @(posedge clk);
    end
    if (!ok) check("xfer_timeout", 0, 1);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    @(posedge clk);
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    int   s0;
    if (v.bad_en) begin
      send_byte(v.bad_byte);
      @(negedge clk);
      in_valid = 1'b0;
      check("label_err_pulse", label_err, 1);
      check("bad_label_idle", busy, 0);
      check("bad_label_kept", label, label_m);
      @(negedge clk);
      check("label_err_one_cycle", label_err, 0);
    end
    e.lbl = v.exp_label;
    for (int k = 0; k < NP; k++) e.img[8*k +: 8] = 8'((k * v.mul + v.add) % 256);
    sb.push_back(e);
    s0 = starts;
    send_byte(v.lbl_byte);
    for (int k = 0; k < NP; k++) begin
      if (v.gappy && $urandom_range(0, 1) == 1) idle_cycle();
      send_byte(e.img[8*k +: 8]);
    end
    // LAUNCH cycle: junk offered on the input, optional early done
    @(negedge clk);
    in_valid       = 1'b1;
    in_data        = 8'hAA;
    done           = v.early_done;
    classification = v.cls;
    check("start_after_last", start, 1);
    @(negedge clk);
    done = 1'b0;
    check("start_one_cycle", start, 0);
    check("wait_busy", busy, 1);
    check("wait_not_ready", in_ready, 0);
    check("one_start", starts - s0, 1);
    repeat (3) @(negedge clk);
    check("early_done_ignored", busy, 1);
    check_img("image_hold", e.img);
    check("label_hold", label, v.exp_label);
    check("fc_before_done", frame_count, exp_cnt(fc_m));
    done = 1'b1;
    @(negedge clk);
    done     = 1'b0;
    in_valid = 1'b0;
    fc_m    = sat_inc(fc_m);
    if (v.exp_correct) cc_m = sat_inc(cc_m);
    label_m = v.exp_label;
    check("no_bubble_idle", busy, 0);
    check("no_bubble_ready", in_ready, 1);
    check("frame_count", frame_count, exp_cnt(fc_m));
    check("correct_count", correct_count, exp_cnt(cc_m));
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{bad_en:1'b0, bad_byte:8'h00, lbl_byte:8'h07, mul:1, add:0, gappy:1'b0,
                early_done:1'b0, cls:4'd7, exp_label:4'd7, exp_correct:1'b1};
    vecs[1] = '{bad_en:1'b1, bad_byte:8'h0C, lbl_byte:8'h03, mul:3, add:5, gappy:1'b1,
                early_done:1'b0, cls:4'd2, exp_label:4'd3, exp_correct:1'b0};
    vecs[2] = '{bad_en:1'b1, bad_byte:8'h0A, lbl_byte:8'h09, mul:7, add:11, gappy:1'b1,
                early_done:1'b1, cls:4'd9, exp_label:4'd9, exp_correct:1'b1};
    vecs[3] = '{bad_en:1'b0, bad_byte:8'h00, lbl_byte:8'h00, mul:0, add:255, gappy:1'b0,
                early_done:1'b0, cls:4'd1, exp_label:4'd0, exp_correct:1'b0};
    vecs[4] = '{bad_en:1'b0, bad_byte:8'h00, lbl_byte:8'h02, mul:5, add:1, gappy:1'b0,
                early_done:1'b0, cls:4'd2, exp_label:4'd2, exp_correct:1'b1};

    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; done = 1'b0; classification = 4'd0;
    repeat (2) @(negedge clk);
    check("rst_label", label, 0);
    check_img("rst_image", '0);
    check("rst_start", start, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", in_ready, 1);
    check("rst_label_err", label_err, 0);
    check("rst_fc", frame_count, 0);
    check("rst_cc", correct_count, 0);
    rst = 1'b0;

    for (int i = 0; i < 3; i++) run_vec(vecs[i]);

    // Reset in the middle of a frame: everything clears at once, frame abandoned
    begin
      exp_t e;
      e.lbl = 4'd5;
      for (int k = 0; k < NP; k++) e.img[8*k +: 8] = 8'(k + 17);
      sb.push_back(e);
      send_byte(8'h05);
      for (int k = 0; k < 400; k++) send_byte(e.img[8*k +: 8]);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("midrst_label", label, 0);
      check_img("midrst_image", '0);
      check("midrst_start", start, 0);
      check("midrst_label_err", label_err, 0);
      check("midrst_busy", busy, 0);
      check("midrst_ready", in_ready, 1);
      check("midrst_fc", frame_count, 0);
      check("midrst_cc", correct_count, 0);
      sb.delete(sb.size() - 1);
      fc_m = 0; cc_m = 0; label_m = 4'd0;
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0;
      done = 1'b1; classification = 4'd0;
      @(negedge clk);
      done = 1'b0;
      check("stray_done_busy", busy, 0);
      check("stray_done_fc", frame_count, exp_cnt(fc_m));
    end

    run_vec(vecs[3]);

    // Saturation: preload both counters to all-ones, then one correct frame
`ifdef LOADER_STATS_EN
    @(negedge clk);
    force dut.u_frame_cnt.r_cnt = 16'hFFFF;
    force dut.u_correct_cnt.r_cnt = 16'hFFFF;
    #1;
    release dut.u_frame_cnt.r_cnt;
    release dut.u_correct_cnt.r_cnt;
    fc_m = 65535; cc_m = 65535;
`endif
    @(negedge clk);
    check("preload_fc", frame_count, exp_cnt(fc_m));
    check("preload_cc", correct_count, exp_cnt(cc_m));
    run_vec(vecs[4]);
    check("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
